// File: rtl/pipe_pkg.sv
// Shared types and constants for the valid/ready pipeline stage register.
// The stage FSM tracks how many beats are held; occupancy is derived from it.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    SKID_FULL = 2'd2
  } stage_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  function automatic logic [1:0] occ_of(input stage_state_t s);
    case (s)
      FULL:      occ_of = OCC_ONE;
      SKID_FULL: occ_of = OCC_TWO;
      default:   occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/stage_entry_reg.sv
// One held beat: valid flag plus {data, rd, ctrl}. clear wins over load so a
// flush always empties the entry; ctrl is zeroed whenever the entry empties.
module stage_entry_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned CTRL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [RD_W-1:0]   rd,
  output logic [CTRL_W-1:0] ctrl
);

  // NOTE: the payload is a handful of flops, not a RAM, so it is reset along
  // with valid; that makes out_data/out_rd read 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      valid <= 1'b0;
      data  <= '0;
      rd    <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      rd    <= in_rd;
      ctrl  <= in_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry
// skid buffer (registered in_ready), synchronous flush and zeroed bubble ctrl.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  stage_state_t state_q, state_d;

  logic in_fire, out_fire;
  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;

  logic              main_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic [RD_W-1:0]   main_rd,   skid_rd,   main_d_rd;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;

  // With the skid entry, in_ready comes only from the state flops, which
  // breaks the combinational out_ready -> in_ready path through the pipeline.
  assign in_ready = (SKID != 0) ? (state_q != SKID_FULL)
                                : (!main_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = FULL;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire && (SKID != 0)) begin
            skid_load = 1'b1;
            state_d   = SKID_FULL;
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_d_data = main_from_skid ? skid_data : in_data;
  assign main_d_rd   = main_from_skid ? skid_rd   : in_rd;
  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  stage_entry_reg #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .in_data (main_d_data),
    .in_rd   (main_d_rd),
    .in_ctrl (main_d_ctrl),
    .valid   (main_valid),
    .data    (main_data),
    .rd      (main_rd),
    .ctrl    (main_ctrl)
  );

  if (SKID != 0) begin : g_skid
    logic skid_valid;
    stage_entry_reg #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load    (skid_load),
      .clear   (skid_clear),
      .in_data (in_data),
      .in_rd   (in_rd),
      .in_ctrl (in_ctrl),
      .valid   (skid_valid),
      .data    (skid_data),
      .rd      (skid_rd),
      .ctrl    (skid_ctrl)
    );
  end else begin : g_no_skid
    assign skid_data = '0;
    assign skid_rd   = '0;
    assign skid_ctrl = '0;
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_rd    = main_rd;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign occupancy = occ_of(state_q);

endmodule
